seq_detector_prog: RTL and testbench

Runtime-programmable serial bit-pattern detector. It succeeds the fixed 4-bit "1011" detector FSM and sits on the same serial-input paths.
- Pattern length is 1..MAX_LEN bits and loaded through a config port.
- Mode is overlapping or non-overlapping.
- Input is qualified by a valid strobe.
- Provides a registered match pulse and a saturating match counter for status readback.

---
 rtl/seq_det_pkg.sv | 27 ++
 rtl/sat_counter.sv | 27 ++
 rtl/seq_detector_prog.sv | 123 ++++++++++++
 tb/tb_seq_detector_prog.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

  // Widest pattern the config type can carry.
  localparam int MAX_LEN_LIMIT = 64;
  localparam int LEN_W_LIMIT   = 7;

  // Bits needed to hold a length value in 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // One complete detector configuration.
  typedef struct packed {
    logic [MAX_LEN_LIMIT-1:0] pattern;
    logic [LEN_W_LIMIT-1:0]   len;
    logic                     overlap;
  } cfg_t;

  // Power-up configuration: non-overlapping "1011", same as the legacy detector.
  localparam cfg_t DEF_RST_CFG = '{
    pattern: 64'b1011,
    len:     7'd4,
    overlap: 1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  // Count up on inc, stick at all-ones, clear on request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with registered match
// pulse and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 16,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_CFG.pattern),
  parameter int                 RST_LEN     = int'(DEF_RST_CFG.len),
  parameter bit                 RST_OVERLAP = DEF_RST_CFG.overlap,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] RST_LEN_V = LEN_W'(RST_LEN);
  localparam logic             RST_ERR   = (RST_LEN == 0) || (RST_LEN > MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_FILL  = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN:0] ONE_W     = (MAX_LEN + 1)'(1);

  // Active configuration
  logic [MAX_LEN-1:0] pat_reg,     pat_next;
  logic [LEN_W-1:0]   len_reg,     len_next;
  logic               overlap_reg, overlap_next;
  logic               err_reg,     err_next;

  // Detection state
  logic [MAX_LEN-1:0] hist_reg,  hist_next;
  logic [LEN_W-1:0]   fill_reg,  fill_next;
  logic               match_reg, match_next;

  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN:0]   mask_w;
  logic               window_eq;
  logic               hit;

  // Candidate history/fill if the current bit is accepted. The mask is one
  // bit wider than the history so len == MAX_LEN does not overflow the shift.
  always_comb begin
    hist_shift = {hist_reg[MAX_LEN-2:0], in_bit};
    fill_inc   = (fill_reg == MAX_FILL) ? fill_reg : fill_reg + LEN_W'(1);
    mask_w     = (ONE_W << len_reg) - ONE_W;
    window_eq  = ((({1'b0, hist_shift} ^ {1'b0, pat_reg}) & mask_w) == '0);
  end

  // Next-state: a config load takes priority and swallows any coincident bit;
  // otherwise a valid bit shifts in and may complete a match.
  always_comb begin
    pat_next     = pat_reg;
    len_next     = len_reg;
    overlap_next = overlap_reg;
    err_next     = err_reg;
    hist_next    = hist_reg;
    fill_next    = fill_reg;
    hit          = 1'b0;

    if (cfg_load) begin
      pat_next     = cfg_pattern;
      len_next     = cfg_len;
      overlap_next = cfg_overlap;
      err_next     = (cfg_len == '0) || (cfg_len > MAX_FILL);
      hist_next    = '0;
      fill_next    = '0;
    end else if (in_valid) begin
      hist_next = hist_shift;
      fill_next = fill_inc;
      hit       = (fill_inc >= len_reg) && window_eq && !err_reg;
      // Non-overlapping: the matched window must not seed the next match.
      if (hit && !overlap_reg) begin
        fill_next = '0;
      end
    end

    match_next = hit;
  end

  // State register; reset restores the power-up configuration and drops history.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pat_reg     <= RST_PATTERN;
      len_reg     <= RST_LEN_V;
      overlap_reg <= RST_OVERLAP;
      err_reg     <= RST_ERR;
      hist_reg    <= '0;
      fill_reg    <= '0;
      match_reg   <= 1'b0;
    end else begin
      pat_reg     <= pat_next;
      len_reg     <= len_next;
      overlap_reg <= overlap_next;
      err_reg     <= err_next;
      hist_reg    <= hist_next;
      fill_reg    <= fill_next;
      match_reg   <= match_next;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clear),
    .inc  (hit),
    .q    (match_count)
  );

  assign match   = match_reg;
  assign cfg_err = err_reg;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: the driver queues the expected
// outputs for every cycle it drives, the monitor pops and compares them.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 5;

  logic               clk = 1'b0;
  logic               rstn;
  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clear;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  seq_detector_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clear   (cnt_clear),
    .match       (match),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [1:0] cnt;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         txn    = 0;
  logic [1:0] m_cnt  = 2'd0;
  logic       m_err  = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL txn %0d %s: got %0d expected %0d", txn, name, act, req);
    end
  endtask

  // Monitor: one queued expectation per clock, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("txn %0d match=%0d count=%0d cfg_err=%0d", txn, match, match_count, cfg_err);
      chk("match", int'(match), int'(e.m));
      chk("match_count", int'(match_count), int'(e.cnt));
      chk("cfg_err", int'(cfg_err), int'(e.err));
      txn++;
    end
  end

  // Drive one cycle and queue what the outputs must look like after its edge.
  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [15:0] pat, input logic [4:0] len, input logic ov,
                      input logic clr, input logic rst, input logic em);
    exp_t e;
    @(negedge clk);
    rstn        = ~rst;
    in_valid    = v;
    in_bit      = b;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cnt_clear   = clr;
    if (rst) begin
      m_cnt = 2'd0;
      m_err = 1'b0;
    end else begin
      if (ld) m_err = (len == 5'd0) || (len > 5'd16);
      if (clr) m_cnt = 2'd0;
      else if (em && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    end
    e.m   = rst ? 1'b0 : em;
    e.cnt = m_cnt;
    e.err = m_err;
    sb_q.push_back(e);
  endtask

  task automatic bit_in(input logic b, input logic em);
    step(1'b1, b, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, em);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [15:0] pat, input logic [4:0] len, input logic ov, input logic clr);
    step(1'b0, 1'b0, 1'b1, pat, len, ov, clr, 1'b0, 1'b0);
  endtask

  task automatic rst_cycle();
    step(1'b1, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Feed n bits, MSB of the n-bit field first, with hand-computed match flags.
  task automatic feed(input logic [63:0] bits, input int n, input logic [63:0] exp_m);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i], exp_m[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clear = 1'b0;

    rst_cycle();
    rst_cycle();

    // 1: default non-overlapping 1011 on 1011011
    feed(64'b1011011, 7, 64'b0001000);

    // 2: overlapping 1011 on 1011011
    load(16'b1011, 5'd4, 1'b1, 1'b1);
    feed(64'b1011011, 7, 64'b0001001);

    // 3: default config, three idle cycles between bits
    load(16'b1011, 5'd4, 1'b0, 1'b1);
    bit_in(1'b1, 1'b0); idle(); idle(); idle();
    bit_in(1'b0, 1'b0); idle(); idle(); idle();
    bit_in(1'b1, 1'b0); idle(); idle(); idle();
    bit_in(1'b1, 1'b1); idle();

    // 4: load A5/len 8 (upper pattern bits junk) with a coincident valid bit
    step(1'b1, 1'b1, 1'b1, 16'hFFA5, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    feed(64'b10100101, 8, 64'b00000001);
    load(16'h0000, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) bit_in(1'($urandom_range(0, 1)), 1'b0);
    load(16'h0001, 5'd17, 1'b1, 1'b0);
    feed(64'b1111, 4, 64'b0000);
    // full-width pattern: mask boundary at len == MAX_LEN
    load(16'hBEEF, 5'd16, 1'b0, 1'b0);
    feed(64'hBEEF, 16, 64'h0001);

    // 5: single-bit overlapping pattern, counter saturation, clear vs hit
    load(16'h0001, 5'd1, 1'b1, 1'b1);
    feed(64'b11111, 5, 64'b11111);
    step(1'b1, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    bit_in(1'b0, 1'b0);

    // 6: reset mid-sequence discards history
    load(16'b1011, 5'd4, 1'b0, 1'b1);
    feed(64'b101, 3, 64'b000);
    rst_cycle();
    bit_in(1'b1, 1'b0);
    feed(64'b011, 3, 64'b001);
    idle();

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
